// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the three requester handshakes plus the byte-wide RAM/IO port.
// The slave modport is the arbiter; master is the surrounding system (requesters and RAM).
interface mem_arbiter_if #(
    parameter int LINE_BYTES = 16
);
    logic                    rdy;

    logic                    valid_from_inst_fetcher;
    logic [31:0]             addr_from_inst_fetcher;
    logic                    ready_to_inst_fetcher;
    logic [8*LINE_BYTES-1:0] cache_line_to_inst_fetcher;

    logic                    valid_from_ls_buffer;
    logic                    rw_flag_from_ls_buffer;
    logic [31:0]             addr_from_ls_buffer;
    logic [8*LINE_BYTES-1:0] cache_line_from_ls_buffer;
    logic                    ready_to_ls_buffer;
    logic [8*LINE_BYTES-1:0] cache_line_to_ls_buffer;

    logic                    valid_from_io;
    logic                    rw_flag_from_io;
    logic [31:0]             addr_from_io;
    logic [7:0]              byte_from_io;
    logic                    ready_to_io;
    logic [7:0]              byte_to_io;

    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [31:0]             mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    modport slave (
        input  rdy,
        input  valid_from_inst_fetcher, addr_from_inst_fetcher,
        output ready_to_inst_fetcher, cache_line_to_inst_fetcher,
        input  valid_from_ls_buffer, rw_flag_from_ls_buffer, addr_from_ls_buffer,
        input  cache_line_from_ls_buffer,
        output ready_to_ls_buffer, cache_line_to_ls_buffer,
        input  valid_from_io, rw_flag_from_io, addr_from_io, byte_from_io,
        output ready_to_io, byte_to_io,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy,
        output valid_from_inst_fetcher, addr_from_inst_fetcher,
        input  ready_to_inst_fetcher, cache_line_to_inst_fetcher,
        output valid_from_ls_buffer, rw_flag_from_ls_buffer, addr_from_ls_buffer,
        output cache_line_from_ls_buffer,
        input  ready_to_ls_buffer, cache_line_to_ls_buffer,
        output valid_from_io, rw_flag_from_io, addr_from_io, byte_from_io,
        input  ready_to_io, byte_to_io,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter owning the byte-wide RAM/IO port: grants IO, load/store and fetch requests and
// runs each as byte-serial RAM cycles, returning whole lines or single bytes.
module mem_arbiter #(
    parameter int LINE_BYTES = 16,
    parameter int LINE_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int                    LINE_BITS = 8 * LINE_BYTES;
    localparam logic [LINE_WIDTH-1:0] LAST_BYTE = LINE_WIDTH'(LINE_BYTES - 1);
    localparam logic [31:0]           BASE_MASK = ~32'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_LINE,
        WRITE_LINE,
        READ_IO,
        WRITE_IO,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PORT_IF,
        PORT_LS,
        PORT_IO
    } port_t;

    state_t                state, state_next;
    port_t                 port;
    logic                  favour_if;
    logic                  frozen;
    logic [31:0]           base;
    logic [LINE_BITS-1:0]  wr_line;
    logic [LINE_BITS-1:0]  work_line;
    logic [LINE_BITS-1:0]  merged_line;
    logic [LINE_BITS-1:0]  if_line;
    logic [LINE_BITS-1:0]  ls_line;
    logic [7:0]            wr_byte;
    logic [7:0]            io_byte;
    logic [LINE_WIDTH:0]   issue;
    logic [LINE_WIDTH:0]   issue_eff;
    logic [LINE_WIDTH-1:0] cap;
    logic                  capture;
    logic                  last_capture;
    logic                  grant_if;
    logic                  grant_ls;
    logic                  grant_io;

    assign grant_io = bus.valid_from_io;
    assign grant_ls = !bus.valid_from_io && bus.valid_from_ls_buffer
                      && !(bus.valid_from_inst_fetcher && favour_if);
    assign grant_if = !bus.valid_from_io && bus.valid_from_inst_fetcher
                      && !(bus.valid_from_ls_buffer && !favour_if);

    // After a freeze the first active cycle re-issues the byte whose read data was lost.
    assign issue_eff    = (bus.rdy && frozen) ? {1'b0, cap} : issue;
    assign capture      = bus.rdy && !frozen && (issue != {1'b0, cap});
    assign last_capture = capture && (cap == LAST_BYTE);

    always_comb begin
        merged_line = work_line;
        merged_line[{cap, 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.rdy) begin
            case (state)
                IDLE: begin
                    if (grant_io) begin
                        state_next = bus.rw_flag_from_io ? WRITE_IO : READ_IO;
                    end else if (grant_ls) begin
                        state_next = bus.rw_flag_from_ls_buffer ? WRITE_LINE : READ_LINE;
                    end else if (grant_if) begin
                        state_next = READ_LINE;
                    end
                end
                READ_LINE:  if (last_capture) state_next = DONE;
                WRITE_LINE: if (issue[LINE_WIDTH-1:0] == LAST_BYTE) state_next = DONE;
                READ_IO:    if (capture) state_next = DONE;
                WRITE_IO:   if (!bus.io_buffer_full) state_next = DONE;
                DONE:       state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_a                 = '0;
        bus.mem_dout              = '0;
        bus.mem_wr                = 1'b0;
        bus.ready_to_inst_fetcher = 1'b0;
        bus.ready_to_ls_buffer    = 1'b0;
        bus.ready_to_io           = 1'b0;
        case (state)
            READ_LINE: bus.mem_a = base + 32'(issue_eff);
            WRITE_LINE: begin
                bus.mem_a    = base + 32'(issue);
                bus.mem_dout = wr_line[{issue[LINE_WIDTH-1:0], 3'b000} +: 8];
                bus.mem_wr   = bus.rdy;
            end
            READ_IO: bus.mem_a = base;
            WRITE_IO: begin
                bus.mem_a    = base;
                bus.mem_dout = wr_byte;
                bus.mem_wr   = bus.rdy && !bus.io_buffer_full;
            end
            DONE: begin
                bus.ready_to_inst_fetcher = (port == PORT_IF);
                bus.ready_to_ls_buffer    = (port == PORT_LS);
                bus.ready_to_io           = (port == PORT_IO);
            end
            default: ;
        endcase
    end

    assign bus.cache_line_to_inst_fetcher = if_line;
    assign bus.cache_line_to_ls_buffer    = ls_line;
    assign bus.byte_to_io                 = io_byte;

    // Lines are assembled in work_line and only copied to a port's output on completion,
    // so each port's data stays stable until its own next transaction finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port      <= PORT_LS;
            favour_if <= 1'b0;
            frozen    <= 1'b0;
            base      <= '0;
            wr_line   <= '0;
            wr_byte   <= '0;
            work_line <= '0;
            if_line   <= '0;
            ls_line   <= '0;
            io_byte   <= '0;
            issue     <= '0;
            cap       <= '0;
        end else begin
            frozen <= !bus.rdy;
            if (bus.rdy) begin
                case (state)
                    IDLE: begin
                        issue <= '0;
                        cap   <= '0;
                        if (grant_io) begin
                            port    <= PORT_IO;
                            base    <= bus.addr_from_io;
                            wr_byte <= bus.byte_from_io;
                        end else if (grant_ls) begin
                            port      <= PORT_LS;
                            base      <= bus.addr_from_ls_buffer & BASE_MASK;
                            wr_line   <= bus.cache_line_from_ls_buffer;
                            favour_if <= 1'b1;
                        end else if (grant_if) begin
                            port      <= PORT_IF;
                            base      <= bus.addr_from_inst_fetcher & BASE_MASK;
                            favour_if <= 1'b0;
                        end
                    end
                    READ_LINE, READ_IO: begin
                        issue <= issue_eff + 1'b1;
                        if (capture) begin
                            cap       <= cap + 1'b1;
                            work_line <= merged_line;
                            if (state == READ_IO) begin
                                io_byte <= bus.mem_din;
                            end else if (last_capture) begin
                                if (port == PORT_IF) begin
                                    if_line <= merged_line;
                                end else begin
                                    ls_line <= merged_line;
                                end
                            end
                        end
                    end
                    WRITE_LINE: issue <= issue + 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: line read/write, IO write backpressure, rdy freeze,
// round-robin contention with IO priority, and asynchronous reset mid-write.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.LINE_BYTES(16)) bus ();

    mem_arbiter #(.LINE_BYTES(16), .LINE_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM model: real storage below 0x100, elsewhere a byte reads as its low address byte.
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_wr && bus.mem_a[31:8] == 24'h0) ram[bus.mem_a[7:0]] <= bus.mem_dout;
        bus.mem_din <= (bus.mem_a[31:8] == 24'h0) ? ram[bus.mem_a[7:0]] : bus.mem_a[7:0];
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_any(input int budget, output logic [2:0] seen, output int cycles);
        seen   = 3'b000;
        cycles = 0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            seen = {bus.ready_to_io, bus.ready_to_ls_buffer, bus.ready_to_inst_fetcher};
            if (seen != 3'b000) begin
                cycles = c;
                break;
            end
        end
    endtask

    function automatic logic [127:0] pattern_line(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'(base + 32'(i));
        return l;
    endfunction

    initial begin
        logic [2:0]   seen;
        int           cyc;
        logic [127:0] wline;
        logic [127:0] got;

        rst                           = 1'b0;
        bus.rdy                       = 1'b1;
        bus.valid_from_inst_fetcher   = 1'b0;
        bus.addr_from_inst_fetcher    = '0;
        bus.valid_from_ls_buffer      = 1'b0;
        bus.rw_flag_from_ls_buffer    = 1'b0;
        bus.addr_from_ls_buffer       = '0;
        bus.cache_line_from_ls_buffer = '0;
        bus.valid_from_io             = 1'b0;
        bus.rw_flag_from_io           = 1'b0;
        bus.addr_from_io              = '0;
        bus.byte_from_io              = '0;
        bus.io_buffer_full            = 1'b0;
        tick(2);
        check("rst_mem_a", bus.mem_a, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_ready", {bus.ready_to_io, bus.ready_to_ls_buffer, bus.ready_to_inst_fetcher}, 0);
        rst = 1'b1;
        tick();

        $display("[TB] line read by inst_fetcher");
        bus.valid_from_inst_fetcher = 1'b1;
        bus.addr_from_inst_fetcher  = 32'h0000_1004;
        tick();
        bus.valid_from_inst_fetcher = 1'b0;
        bus.addr_from_inst_fetcher  = 32'hDEAD_BEEF;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("rd_addr%0d", k), bus.mem_a, 32'h1000 + k);
            tick();
        end
        wait_any(40, seen, cyc);
        check("rd_ready", seen, 3'b001);
        check("rd_latency", 17 + cyc, 18);
        check("rd_line", bus.cache_line_to_inst_fetcher, 128'h0F0E0D0C0B0A09080706050403020100);
        tick();
        check("rd_ready_pulse", bus.ready_to_inst_fetcher, 0);

        $display("[TB] line write by ls_buffer");
        for (int i = 0; i < 16; i++) wline[8*i +: 8] = 8'hA0 + 8'(i);
        bus.valid_from_ls_buffer      = 1'b1;
        bus.rw_flag_from_ls_buffer    = 1'b1;
        bus.addr_from_ls_buffer       = 32'h0000_0025;
        bus.cache_line_from_ls_buffer = wline;
        tick();
        bus.valid_from_ls_buffer = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wr_en%0d", i), bus.mem_wr, 1);
            check($sformatf("wr_addr%0d", i), bus.mem_a, 32'h20 + i);
            check($sformatf("wr_data%0d", i), bus.mem_dout, 8'hA0 + i);
            tick();
        end
        check("wr_ready", {bus.ready_to_io, bus.ready_to_ls_buffer, bus.ready_to_inst_fetcher}, 3'b010);
        check("wr_done_no_wr", bus.mem_wr, 0);
        for (int i = 0; i < 16; i++) got[8*i +: 8] = ram[8'h20 + 8'(i)];
        check("wr_ram", got, wline);
        tick();

        $display("[TB] line read back by ls_buffer");
        bus.valid_from_ls_buffer   = 1'b1;
        bus.rw_flag_from_ls_buffer = 1'b0;
        bus.addr_from_ls_buffer    = 32'h0000_0020;
        tick();
        bus.valid_from_ls_buffer = 1'b0;
        wait_any(40, seen, cyc);
        check("rb_ready", seen, 3'b010);
        check("rb_latency", 1 + cyc, 18);
        check("rb_line", bus.cache_line_to_ls_buffer, wline);
        tick();

        $display("[TB] IO write with io_buffer_full");
        bus.io_buffer_full  = 1'b1;
        bus.valid_from_io   = 1'b1;
        bus.rw_flag_from_io = 1'b1;
        bus.addr_from_io    = 32'h0003_0000;
        bus.byte_from_io    = 8'h41;
        tick();
        bus.valid_from_io = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("io_wait%0d", c), bus.mem_wr, 0);
            tick();
        end
        bus.io_buffer_full = 1'b0;
        #1;
        check("io_wr_en", bus.mem_wr, 1);
        check("io_wr_addr", bus.mem_a, 32'h0003_0000);
        check("io_wr_data", bus.mem_dout, 8'h41);
        tick();
        check("io_ready", {bus.ready_to_io, bus.ready_to_ls_buffer, bus.ready_to_inst_fetcher}, 3'b100);
        check("io_single_wr", bus.mem_wr, 0);
        tick();

        $display("[TB] rdy freeze during line read");
        bus.valid_from_inst_fetcher = 1'b1;
        bus.addr_from_inst_fetcher  = 32'h0000_4058;
        tick();
        bus.valid_from_inst_fetcher = 1'b0;
        tick(8);
        check("fz_addr_before", bus.mem_a, 32'h4058);
        bus.rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("fz_no_wr%0d", c), bus.mem_wr, 0);
            check($sformatf("fz_addr%0d", c), bus.mem_a, 32'h4058);
        end
        bus.rdy = 1'b1;
        #1;
        check("fz_reissue", bus.mem_a, 32'h4057);
        wait_any(40, seen, cyc);
        check("fz_ready", seen, 3'b001);
        check("fz_latency", 12 + cyc, 22);
        check("fz_line", bus.cache_line_to_inst_fetcher, pattern_line(32'h4050));
        tick();

        $display("[TB] contention with IO request mid-line");
        bus.valid_from_inst_fetcher = 1'b1;
        bus.addr_from_inst_fetcher  = 32'h0000_3080;
        bus.valid_from_ls_buffer    = 1'b1;
        bus.rw_flag_from_ls_buffer  = 1'b0;
        bus.addr_from_ls_buffer     = 32'h0000_2040;
        wait_any(40, seen, cyc);
        check("ct_first_ls", seen, 3'b010);
        tick(5);
        bus.valid_from_io   = 1'b1;
        bus.rw_flag_from_io = 1'b0;
        bus.addr_from_io    = 32'h0003_0005;
        wait_any(40, seen, cyc);
        check("ct_second_if", seen, 3'b001);
        check("ct_if_line", bus.cache_line_to_inst_fetcher, pattern_line(32'h3080));
        wait_any(40, seen, cyc);
        check("ct_io_first", seen, 3'b100);
        check("ct_io_byte", bus.byte_to_io, 8'h05);
        bus.valid_from_io = 1'b0;
        wait_any(40, seen, cyc);
        check("ct_third_ls", seen, 3'b010);
        check("ct_ls_line", bus.cache_line_to_ls_buffer, pattern_line(32'h2040));
        bus.valid_from_inst_fetcher = 1'b0;
        bus.valid_from_ls_buffer    = 1'b0;
        tick();

        $display("[TB] reset during line write");
        bus.valid_from_ls_buffer      = 1'b1;
        bus.rw_flag_from_ls_buffer    = 1'b1;
        bus.addr_from_ls_buffer       = 32'h0000_0040;
        bus.cache_line_from_ls_buffer = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        tick();
        bus.valid_from_ls_buffer = 1'b0;
        tick(4);
        check("rs_mid_write", bus.mem_wr, 1);
        rst = 1'b0;
        #1;
        check("rs_mem_wr", bus.mem_wr, 0);
        check("rs_mem_a", bus.mem_a, 0);
        check("rs_mem_dout", bus.mem_dout, 0);
        check("rs_if_line", bus.cache_line_to_inst_fetcher, 0);
        check("rs_io_byte", bus.byte_to_io, 0);
        tick(2);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rs_no_ready%0d", c),
                  {bus.ready_to_io, bus.ready_to_ls_buffer, bus.ready_to_inst_fetcher}, 0);
        end
        bus.valid_from_inst_fetcher = 1'b1;
        bus.addr_from_inst_fetcher  = 32'h0000_5000;
        tick();
        bus.valid_from_inst_fetcher = 1'b0;
        wait_any(40, seen, cyc);
        check("rs_after_ready", seen, 3'b001);
        check("rs_after_latency", 1 + cyc, 18);
        check("rs_after_line", bus.cache_line_to_inst_fetcher, pattern_line(32'h5000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide RAM/IO port.
- Arbitrates between three requesters:
  - instruction-fetch line reads;
  - load/store cache-line reads and writebacks;
  - load/store single-byte IO accesses.
- Sequences each granted transaction as byte-serial RAM cycles and returns whole cache lines or single bytes via a valid/ready handshake.

Parameters:
- LINE_BYTES, 16, bytes per cache line; power of two, ≥2.
- LINE_WIDTH, 4, log2(LINE_BYTES).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; low freezes the block.
- valid_from_inst_fetcher  input  1  line-read request.
- addr_from_inst_fetcher  input  32  byte address; low LINE_WIDTH bits ignored.
- ready_to_inst_fetcher  output  1  one-cycle completion pulse.
- cache_line_to_inst_fetcher  output  8*LINE_BYTES  filled line.
- valid_from_ls_buffer  input  1  line request.
- rw_flag_from_ls_buffer  input  1  0 = read, 1 = write.
- addr_from_ls_buffer  input  32  byte address; low bits ignored.
- cache_line_from_ls_buffer  input  8*LINE_BYTES  writeback data.
- ready_to_ls_buffer  output  1  completion pulse.
- cache_line_to_ls_buffer  output  8*LINE_BYTES  filled line.
- valid_from_io  input  1  IO byte request.
- rw_flag_from_io  input  1  0 = read, 1 = write.
- addr_from_io  input  32  IO address.
- byte_from_io  input  8  write byte.
- ready_to_io  output  1  completion pulse.
- byte_to_io  output  8  read byte.
- mem_din  input  8  RAM read data; valid one cycle after address.
- mem_dout  output  8  RAM write data.
- mem_a  output  32  RAM address.
- mem_wr  output  1  1 = write this cycle.
- io_buffer_full  input  1  IO sink cannot accept a write.

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0, state IDLE, counters 0;
  - round-robin pointer favours ls_buffer;
  - in-flight transaction discarded.
- rdy low: state, counters, captured data and outputs frozen, except mem_wr forced 0. See the freeze rule below for reads.
- States: IDLE, READ_LINE, WRITE_LINE, READ_IO, WRITE_IO, DONE.
- Grant (IDLE only):
  - IO has top priority.
  - Otherwise round-robin between ls_buffer and inst_fetcher: the pointer flips to the other port after each line grant. With a single requester, that requester is granted.
  - At grant, latch port id, rw flag, base = addr & ~(LINE_BYTES-1) (IO uses the full address), and the write line/byte.
  - Requester inputs are ignored after grant.
- Line byte ordering: line bits [8i+7:8i] ↔ RAM[base+i].
- READ_LINE:
  - issue counter drives mem_a = base+issue, mem_wr=0;
  - mem_din is captured into byte slot cap one cycle after that address was issued;
  - the transaction takes LINE_BYTES+1 active cycles, then DONE.
- rdy-freeze rule in reads: a byte is captured only if its address was issued in the previous cycle and rdy is high now. On the first rdy-high cycle after a freeze, the issue counter is reset to the capture counter (the byte is re-read).
- WRITE_LINE: LINE_BYTES cycles, mem_wr=1, mem_a = base+i, mem_dout = byte i; then DONE.
- READ_IO: one address cycle and one capture cycle into byte_to_io, then DONE.
- WRITE_IO:
  - while io_buffer_full=1: mem_wr=0, wait;
  - otherwise one cycle with mem_wr=1, mem_a = addr, mem_dout = byte; then DONE.
  - io_buffer_full has no effect on RAM line writes or reads.
- DONE:
  - the granted port's ready is high for exactly this cycle; its read data output is stable from this cycle until that port's next completion;
  - no grant in DONE; next state IDLE, where new requests are sampled. Requesters drop valid, or present a new request, by registered update visible the cycle after ready.
- Idle bus: mem_a=0, mem_wr=0, mem_dout=0.
- Address arithmetic: 32-bit wrap-around.

Test Plan:
- Line read: inst_fetcher valid, addr=0x1004; RAM[0x1000+i]=i → mem_a 0x1000..0x100F on consecutive cycles; ready_to_inst_fetcher pulses 18 cycles after grant; line = 0x0F0E…0100.
- Line write: ls_buffer rw=1, addr=0x20, line bytes 0xA0+i → 16 mem_wr cycles, mem_a 0x20..0x2F, mem_dout 0xA0..0xAF, then ready pulse; RAM content matches.
- Contention: inst_fetcher and ls_buffer both valid continuously → grants alternate ls, if, ls; an IO request raised mid-line is granted immediately after the current DONE, ahead of both line ports.
- IO write: io_buffer_full held 1 for 5 cycles, byte 0x41, addr 0x30000 → mem_wr stays 0 for 5 cycles, then exactly one write cycle, then ready_to_io.
- Freeze: rdy low for 3 cycles during a read at byte 7 → no mem_wr, no captures; byte 7 re-issued; line still correct; completion delayed by 4 cycles total.
- Reset: rst low mid WRITE_LINE → outputs 0 asynchronously; after release, IDLE with no ready pulse; a new request completes normally.
